hub75_capture: RTL and testbench

HUB75_CAPTURE -- requirements
Module: hub75_capture

---
 rtl/hub75_capture.sv | 164 ++++++++++++++++
 tb/tb_hub75_capture.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_capture.sv
// HUB75 panel snooper: synchronizes the panel bus, captures one row per latch, replays it as beats.
// Define HUB75_CAPTURE_OE_MEAS_EN to measure #OE-active cycles per row on oe_cycles.
module hub75_capture #(
    parameter int NUM_COLUMNS = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        clk_pixel,
    input  logic        row_latch,
    input  logic        output_enable_n,
    input  logic [3:0]  row_address,
    input  logic [2:0]  rgb1,
    input  logic [2:0]  rgb2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_rgb1,
    output logic [2:0]  out_rgb2,
    output logic [5:0]  out_column,
    output logic [3:0]  out_row,
    output logic        out_last,
    output logic [15:0] oe_cycles,
    output logic        overflow,
    output logic        col_error
);
    localparam int AW = $clog2(NUM_COLUMNS);
    localparam int CW = AW + 1;
    localparam int SW = 13;

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_e;

    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] s;
    logic          pix_prev_q, lat_prev_q;
    logic          pix_s, lat_s, oen_s;
    logic [3:0]    addr_s;
    logic [5:0]    data_s;
    logic          pix_rise, lat_rise, full, pix_store, start, accept, last_beat;
    logic [CW-1:0] fill_count_q, count_q, commit_cnt;
    logic          fill_sel_q;
    logic [AW-1:0] col_q;
    logic [3:0]    row_q;
    logic [5:0]    pix_q;
    logic          overflow_q, col_error_q;
    logic [5:0]    buf_q [2][NUM_COLUMNS];
    state_e        state_q, state_d;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {clk_pixel, row_latch, output_enable_n, row_address, rgb1, rgb2};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s          = sync_q[SYNC_STAGES-1];
    assign pix_s      = s[12];
    assign lat_s      = s[11];
    assign oen_s      = s[10];
    assign addr_s     = s[9:6];
    assign data_s     = s[5:0];
    assign pix_rise   = pix_s & ~pix_prev_q;
    assign lat_rise   = lat_s & ~lat_prev_q;
    assign full       = (fill_count_q == CW'(NUM_COLUMNS));
    assign pix_store  = pix_rise & ~full;
    // A pixel arriving with the latch belongs to the row being committed
    assign commit_cnt = fill_count_q + CW'(pix_store);
    assign start      = lat_rise && (commit_cnt != '0) && (state_q == IDLE);
    assign accept     = out_valid & out_ready;
    assign last_beat  = ((CW'(col_q) + CW'(1)) == count_q);

    always_ff @(posedge clk_in) begin
        if (pix_store) buf_q[fill_sel_q][fill_count_q[AW-1:0]] <= data_s;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = SEND;
            SEND:    if (accept && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == SEND);
        out_last  = (state_q == SEND) && last_beat;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            pix_prev_q   <= 1'b0;
            lat_prev_q   <= 1'b0;
            fill_count_q <= '0;
            fill_sel_q   <= 1'b0;
            count_q      <= '0;
            col_q        <= '0;
            row_q        <= '0;
            pix_q        <= '0;
            overflow_q   <= 1'b0;
            col_error_q  <= 1'b0;
        end else begin
            pix_prev_q <= pix_s;
            lat_prev_q <= lat_s;
            if (pix_rise && full) col_error_q <= 1'b1;
            if (pix_store) fill_count_q <= fill_count_q + CW'(1);
            if (lat_rise) begin
                fill_count_q <= '0;
                if (commit_cnt != '0) begin
                    if (state_q == IDLE) begin
                        fill_sel_q <= ~fill_sel_q;
                        count_q    <= commit_cnt;
                        row_q      <= addr_s;
                        col_q      <= '0;
                    end else begin
                        overflow_q <= 1'b1;
                    end
                end
            end
            // The drain buffer is always the one not being filled
            if (state_q == LOAD) pix_q <= buf_q[~fill_sel_q][col_q];
            if (state_q == SEND && accept && !last_beat) begin
                col_q <= col_q + AW'(1);
                pix_q <= buf_q[~fill_sel_q][col_q + AW'(1)];
            end
        end
    end

    assign out_rgb1   = pix_q[5:3];
    assign out_rgb2   = pix_q[2:0];
    assign out_column = 6'(col_q);
    assign out_row    = row_q;
    assign overflow   = overflow_q;
    assign col_error  = col_error_q;

`ifdef HUB75_CAPTURE_OE_MEAS_EN
    logic [15:0] oe_cnt_q, oe_cycles_q;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            oe_cnt_q    <= '0;
            oe_cycles_q <= '0;
        end else if (lat_rise) begin
            oe_cycles_q <= oe_cnt_q;
            oe_cnt_q    <= '0;
        end else if (!oen_s && oe_cnt_q != 16'hFFFF) begin
            oe_cnt_q <= oe_cnt_q + 16'd1;
        end
    end

    assign oe_cycles = oe_cycles_q;
`else
    logic unused_oe;
    assign unused_oe = oen_s;
    assign oe_cycles = '0;
`endif
endmodule

// File: tb/tb_hub75_capture.sv
// Scoreboard bench for hub75_capture: directed rows, stalls, overflow, reset mid-drain.
// Stimulus pushes expected beats; a negedge monitor pops and compares accepted beats.
module tb_hub75_capture;
    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        clk_pixel, row_latch, oe_n;
    logic [3:0]  addr;
    logic [2:0]  r1, r2;
    logic        out_ready = 1'b0;
    logic        out_valid, out_last, overflow, col_error;
    logic [2:0]  out_rgb1, out_rgb2;
    logic [5:0]  out_column;
    logic [3:0]  out_row;
    logic [15:0] oe_cycles;

    logic [16:0] sb [$];
    int          st_cmp = 0, st_bad = 0, mon_cmp = 0, mon_bad = 0;
    int          beat_cnt = 0;
    int          ready_mode = 0;
    logic        stall_q = 1'b0;
    logic [16:0] held, cur, expv;

    hub75_capture dut (
        .clk_in(clk_in), .reset(rst_n), .clk_pixel(clk_pixel),
        .row_latch(row_latch), .output_enable_n(oe_n),
        .row_address(addr), .rgb1(r1), .rgb2(r2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rgb1(out_rgb1), .out_rgb2(out_rgb2),
        .out_column(out_column), .out_row(out_row), .out_last(out_last),
        .oe_cycles(oe_cycles), .overflow(overflow), .col_error(col_error)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ~out_ready;
        endcase
    end

    always @(negedge clk_in) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            cur = {out_rgb1, out_rgb2, out_column, out_row, out_last};
            if (stall_q) begin
                mon_cmp++;
                if (!out_valid || cur !== held) begin
                    mon_bad++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h",
                             out_valid, cur, held);
                end
            end
            if (out_valid && out_ready) begin
                beat_cnt++;
                mon_cmp++;
                if (sb.size() == 0) begin
                    mon_bad++;
                    $display("FAIL unexpected_beat: got %h, required no beat", cur);
                end else begin
                    expv = sb.pop_front();
                    if (cur !== expv) begin
                        mon_bad++;
                        $display("FAIL beat: got rgb1=%0d rgb2=%0d col=%0d row=%0d last=%b, required rgb1=%0d rgb2=%0d col=%0d row=%0d last=%b",
                                 cur[16:14], cur[13:11], cur[10:5], cur[4:1], cur[0],
                                 expv[16:14], expv[13:11], expv[10:5], expv[4:1], expv[0]);
                    end
                end
            end
            stall_q = out_valid && !out_ready;
            held    = cur;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        st_cmp++;
        if (act !== exp) begin
            st_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic pixel(input logic [2:0] a, input logic [2:0] b);
        r1 = a;
        r2 = b;
        cyc(2);
        clk_pixel = 1'b1;
        cyc(2);
        clk_pixel = 1'b0;
    endtask

    task automatic latch(input logic [3:0] a);
        addr = a;
        cyc(2);
        row_latch = 1'b1;
        cyc(2);
        row_latch = 1'b0;
        cyc(1);
    endtask

    task automatic expect_beat(input logic [2:0] a, input logic [2:0] b,
                               input int col, input logic [3:0] row, input logic last);
        sb.push_back({a, b, 6'(col), row, last});
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (sb.size() == 0 && !out_valid) break;
            cyc(1);
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        #(90000 * 10 * 1ns);
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        clk_pixel = 1'b0;
        row_latch = 1'b0;
        oe_n = 1'b1;
        addr = '0;
        r1 = '0;
        r2 = '0;
        cyc(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_column", out_column, 0);
        chk("rst_row", out_row, 0);
        chk("rst_rgb", {out_rgb1, out_rgb2}, 0);
        chk("rst_oe", oe_cycles, 0);
        chk("rst_flags", {overflow, col_error}, 0);
        rst_n = 1'b1;
        cyc(2);

        // Full row, constant colour
        ready_mode = 1;
        for (int c = 0; c < 64; c++) expect_beat(3'b101, 3'b010, c, 4'd7, c == 63);
        for (int c = 0; c < 64; c++) pixel(3'b101, 3'b010);
        latch(4'd7);
        wait_drain("full_row_drain", 500);
        chk("full_row_flags", {overflow, col_error}, 0);

        // 70 pixels: only the first 64 are kept
        for (int c = 0; c < 64; c++)
            expect_beat(3'(c), ~3'(c), c, 4'd10, c == 63);
        for (int c = 0; c < 70; c++) pixel(3'(c), ~3'(c));
        latch(4'd10);
        wait_drain("over_row_drain", 500);
        chk("over_row_col_error", col_error, 1);
        chk("over_row_overflow", overflow, 0);

        // Stalled output: later rows are discarded while row 1 waits
        do_reset();
        ready_mode = 0;
        for (int c = 0; c < 64; c++) begin
            expect_beat(3'(c), 3'(c >> 3), c, 4'd1, c == 63);
            pixel(3'(c), 3'(c >> 3));
        end
        latch(4'd1);
        cyc(5);
        chk("stall_valid", out_valid, 1);
        chk("stall_column", out_column, 0);
        for (int c = 0; c < 64; c++) pixel(3'd7, 3'd7);
        latch(4'd2);
        for (int c = 0; c < 64; c++) pixel(3'd0, 3'd0);
        latch(4'd3);
        chk("stall_overflow", overflow, 1);
        ready_mode = 1;
        wait_drain("stall_drain", 500);
        chk("stall_overflow_sticky", overflow, 1);
        chk("stall_col_error", col_error, 0);

        // Short row with toggling ready, then an empty latch
        do_reset();
        ready_mode = 2;
        expect_beat(3'd1, 3'd6, 0, 4'd5, 1'b0);
        expect_beat(3'd2, 3'd5, 1, 4'd5, 1'b0);
        expect_beat(3'd3, 3'd4, 2, 4'd5, 1'b0);
        expect_beat(3'd4, 3'd3, 3, 4'd5, 1'b0);
        expect_beat(3'd7, 3'd0, 4, 4'd5, 1'b1);
        pixel(3'd1, 3'd6);
        pixel(3'd2, 3'd5);
        pixel(3'd3, 3'd4);
        pixel(3'd4, 3'd3);
        pixel(3'd7, 3'd0);
        latch(4'd5);
        wait_drain("short_drain", 200);
        base = beat_cnt;
        latch(4'd6);
        cyc(20);
        chk("empty_row_beats", beat_cnt - base, 0);
        chk("empty_row_valid", out_valid, 0);
        chk("empty_row_flags", {overflow, col_error}, 0);

        // Reset in the middle of a drain
        do_reset();
        ready_mode = 1;
        base = beat_cnt;
        for (int c = 0; c < 64; c++) begin
            expect_beat(3'(c) ^ 3'b011, 3'(c >> 3), c, 4'd9, c == 63);
            pixel(3'(c) ^ 3'b011, 3'(c >> 3));
        end
        latch(4'd9);
        for (int k = 0; k < 500; k++) begin
            @(negedge clk_in);
            #1;
            if (beat_cnt - base >= 30) break;
        end
        chk("mid_reset_reached", beat_cnt - base, 30);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_valid", out_valid, 0);
        chk("mid_reset_last", out_last, 0);
        chk("mid_reset_flags", {overflow, col_error}, 0);
        sb.delete();
        cyc(3);
        rst_n = 1'b1;
        base = beat_cnt;
        cyc(50);
        chk("post_reset_beats", beat_cnt - base, 0);
        expect_beat(3'd6, 3'd1, 0, 4'd12, 1'b0);
        expect_beat(3'd5, 3'd2, 1, 4'd12, 1'b0);
        expect_beat(3'd4, 3'd3, 2, 4'd12, 1'b1);
        pixel(3'd6, 3'd1);
        pixel(3'd5, 3'd2);
        pixel(3'd4, 3'd3);
        latch(4'd12);
        wait_drain("post_reset_drain", 200);

        // #OE measurement; the first empty latch clears counts taken while synchronizers refill
        do_reset();
        latch(4'd0);
        oe_n = 1'b0;
        cyc(100);
        oe_n = 1'b1;
        cyc(5);
        latch(4'd1);
`ifdef HUB75_CAPTURE_OE_MEAS_EN
        chk("oe_100", oe_cycles, 100);
        oe_n = 1'b0;
        cyc(70000);
        oe_n = 1'b1;
        cyc(5);
        latch(4'd2);
        chk("oe_saturate", oe_cycles, 16'hFFFF);
`else
        chk("oe_tied_zero", oe_cycles, 0);
`endif
        cyc(5);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 st_cmp + mon_cmp, st_bad + mon_bad);
        $finish;
    end
endmodule
